i2s_sample_fifo: RTL



---
 rtl/i2s_pkg.sv | 12 +
 rtl/i2s_pair_ram.sv | 26 ++
 rtl/i2s_sample_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S sample types
// Common sample width and stereo pair layout for the capture and buffering stages.
package i2s_pkg;

  localparam int SAMPLE_W = 24;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_pair_ram.sv
// rtl/i2s_pair_ram.sv - stereo pair storage
// One synchronous write port and an asynchronous read port; maps onto distributed RAM.
module i2s_pair_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - stereo sample FIFO between I2S capture and consumers
// Pointers, level and drop accounting live here; pair storage is in i2s_pair_ram.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 24,
  parameter int CNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SAMPLE_W-1:0]       in_left_i,
  input  logic [SAMPLE_W-1:0]       in_right_i,
  input  logic                      in_valid_i,
  output logic [SAMPLE_W-1:0]       out_left_o,
  output logic [SAMPLE_W-1:0]       out_right_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      overflow_o,
  output logic [CNT_W-1:0]          drop_count_o,
  input  logic                      clear_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PW-1:0]    PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           level;
  logic                    overflow;
  logic [CNT_W-1:0]        drop_count;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;
  logic [2*SAMPLE_W-1:0]   head_pair;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop  = !empty && out_ready_i;
  assign push = in_valid_i && (!full || pop);
  assign drop = in_valid_i && full && !pop;

  i2s_pair_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2*SAMPLE_W),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push && !rst_i),
    .waddr_i (wr_ptr[AW-1:0]),
    .wdata_i ({in_left_i, in_right_i}),
    .raddr_i (rd_ptr[AW-1:0]),
    .rdata_o (head_pair)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  // A drop coinciding with clear survives the clear: flag stays set, count restarts at 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf_i) begin
        overflow <= 1'b0;
      end
      if (clear_ovf_i) begin
        drop_count <= drop ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (drop && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid_o  = !empty;
  assign out_left_o   = empty ? '0 : head_pair[2*SAMPLE_W-1:SAMPLE_W];
  assign out_right_o  = empty ? '0 : head_pair[SAMPLE_W-1:0];
  assign level_o      = level;
  assign overflow_o   = overflow;
  assign drop_count_o = drop_count;

endmodule
